// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (read-only) and data access.
// Data side wins conflicts, but no more than MAX_DM_BURST grants in a row while a fetch is waiting.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DM_BURST = 2,
  parameter int TIMEOUT      = 15
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          stall_if_o,
  output logic          stall_dm_o,
  output logic          err_o
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam int SW = $clog2(MAX_DM_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEADBEEF);

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          win_dm_q, win_dm_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          err_q, err_d;
  logic          grant_dm;
  logic          finish;
  logic          abort;
  logic [DW-1:0] resp_data;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tcnt_q      <= '0;
      win_dm_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tcnt_q      <= tcnt_d;
      win_dm_q    <= win_dm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tcnt_d      = tcnt_q;
    win_dm_d    = win_dm_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = err_q;
    grant_dm    = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    resp_data   = mem_rdata_i;

    case (state_q)
      IDLE: begin
        if (dm_req_i || if_req_i) begin
          grant_dm  = dm_req_i && (!if_req_i || (starve_q < SW'(MAX_DM_BURST)));
          mem_req_d = 1'b1;
          tcnt_d    = '0;
          state_d   = XFER;
          if (grant_dm) begin
            win_dm_d    = 1'b1;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            if (if_req_i) starve_d = starve_q + SW'(1);
          end else begin
            win_dm_d   = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr_i;
            starve_d   = '0;
          end
        end
      end
      XFER: begin
        if (mem_ready_i) begin
          finish = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          abort     = 1'b1;
          resp_data = TIMEOUT_DATA;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
        if (finish) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // mem_we_q still reflects the granted direction here
          if (!mem_we_q) begin
            if (win_dm_q) dm_rdata_d = resp_data;
            else          if_rdata_d = resp_data;
          end
          if_ack_d = !win_dm_q;
          dm_ack_d = win_dm_q;
          if (abort) err_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign stall_if_o  = if_req_i & ~if_ack_q;
  assign stall_dm_o  = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timing and arbitration model.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 2;
  localparam int TO   = 15;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic          clock_i = 1'b0;
  logic          reset_n_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;
  logic          stall_if_o;
  logic          stall_dm_o;
  logic          err_o;

  always #5 clock_i = ~clock_i;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DM_BURST(MAXB), .TIMEOUT(TO)) dut (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .stall_if_o  (stall_if_o),
    .stall_dm_o  (stall_dm_o),
    .err_o       (err_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // memory behind the DUT, and the model's own view of what memory should hold
  logic [31:0] slave_mem [16];
  logic [31:0] ref_mem   [16];

  int          cyc, free_cyc, t_dec, t_waits, streak, xk, dm_run;
  bit          busy, t_dm, t_we, t_to, exp_err;
  logic [31:0] t_addr, t_wdata, exp_if_rdata, exp_dm_rdata;

  function automatic int idx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic new_if();
    if_req_i  = 1'b1;
    if_addr_i = 32'($urandom_range(0, 15)) << 2;
  endtask

  task automatic new_dm();
    dm_req_i   = 1'b1;
    dm_we_i    = ($urandom_range(0, 2) == 0);
    dm_addr_i  = 32'($urandom_range(0, 15)) << 2;
    dm_wdata_i = $urandom;
  endtask

  task automatic step(input int p_if, input int p_dm, input int p_to, input bit burst_chk);
    bit          e_ifa, e_dma, e_mreq, done;
    int          last_c, r;
    logic [31:0] val;
    @(posedge clock_i);
    #1;
    cyc++;
    e_ifa = 0; e_dma = 0; e_mreq = 0; done = 0; last_c = -1;
    if (busy) begin
      last_c = t_dec + 1 + (t_to ? TO - 1 : t_waits);
      e_mreq = (cyc > t_dec) && (cyc <= last_c);
      if (cyc == last_c + 1) begin
        done = 1;
        if (t_dm) e_dma = 1; else e_ifa = 1;
        if (t_to) exp_err = 1;
        if (!t_we) begin
          val = t_to ? BAD : ref_mem[idx(t_addr)];
          if (t_dm) exp_dm_rdata = val; else exp_if_rdata = val;
        end else if (!t_to) begin
          ref_mem[idx(t_addr)] = t_wdata;
        end
      end
    end

    check_eq("if_ack",   32'(if_ack_o),   32'(e_ifa));
    check_eq("dm_ack",   32'(dm_ack_o),   32'(e_dma));
    check_eq("mem_req",  32'(mem_req_o),  32'(e_mreq));
    check_eq("mem_we",   32'(mem_we_o),   32'(e_mreq && t_we));
    check_eq("err",      32'(err_o),      32'(exp_err));
    check_eq("if_rdata", if_rdata_o,      exp_if_rdata);
    check_eq("dm_rdata", dm_rdata_o,      exp_dm_rdata);
    check_eq("stall_if", 32'(stall_if_o), 32'(if_req_i && !e_ifa));
    check_eq("stall_dm", 32'(stall_dm_o), 32'(dm_req_i && !e_dma));
    if (e_mreq) begin
      check_eq("mem_addr", mem_addr_o, t_addr);
      if (t_we) check_eq("mem_wdata", mem_wdata_o, t_wdata);
    end
    if (burst_chk) begin
      if (dm_ack_o) begin
        dm_run++;
        check_eq("dm_burst_within_max", 32'(dm_run <= MAXB), 32'd1);
      end
      if (if_ack_o) dm_run = 0;
    end

    if (done) begin
      busy     = 0;
      free_cyc = cyc + 1;
      if (t_dm) begin
        dm_req_i = 1'b0;
        if ($urandom_range(0, 99) < p_dm) new_dm();
      end else begin
        if_req_i = 1'b0;
        if ($urandom_range(0, 99) < p_if) new_if();
      end
    end
    if (!if_req_i && $urandom_range(0, 99) < p_if) new_if();
    if (!dm_req_i && $urandom_range(0, 99) < p_dm) new_dm();

    // arbitration decision for a request sampled while the arbiter is free
    if (!busy && cyc >= free_cyc && (if_req_i || dm_req_i)) begin
      t_dm = dm_req_i && (!if_req_i || streak < MAXB);
      if (t_dm) begin
        if (if_req_i) streak++;
        t_we = dm_we_i; t_addr = dm_addr_i; t_wdata = dm_wdata_i;
      end else begin
        streak = 0;
        t_we = 0; t_addr = if_addr_i; t_wdata = 32'd0;
      end
      r = $urandom_range(0, 99);
      if (r < p_to)          t_waits = $urandom_range(TO, TO + 5);
      else if (r < p_to + 5) t_waits = TO - 1;
      else if (r < 55)       t_waits = 0;
      else                   t_waits = $urandom_range(1, 4);
      t_to  = (t_waits >= TO);
      t_dec = cyc;
      busy  = 1;
    end

    if (mem_req_o) begin
      mem_ready_i = (xk >= t_waits);
      mem_rdata_i = mem_ready_i ? slave_mem[idx(mem_addr_o)] : $urandom;
      if (mem_ready_i && mem_we_o) slave_mem[idx(mem_addr_o)] = mem_wdata_o;
      xk++;
    end else begin
      xk          = 0;
      mem_ready_i = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
    end
  endtask

  initial begin
    reset_n_i   = 1'b0;
    if_req_i    = 1'b0; if_addr_i = '0;
    dm_req_i    = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_rdata_i = '0;   mem_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = $urandom;
      ref_mem[i]   = slave_mem[i];
    end

    repeat (2) @(posedge clock_i);
    #1;
    check_eq("rst_mem_req",   32'(mem_req_o), 32'd0);
    check_eq("rst_mem_we",    32'(mem_we_o),  32'd0);
    check_eq("rst_if_ack",    32'(if_ack_o),  32'd0);
    check_eq("rst_dm_ack",    32'(dm_ack_o),  32'd0);
    check_eq("rst_err",       32'(err_o),     32'd0);
    check_eq("rst_mem_addr",  mem_addr_o,     32'd0);
    check_eq("rst_mem_wdata", mem_wdata_o,    32'd0);
    check_eq("rst_if_rdata",  if_rdata_o,     32'd0);
    check_eq("rst_dm_rdata",  dm_rdata_o,     32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;

    // reset arriving while a data read is stuck waiting for the memory
    dm_req_i  = 1'b1;
    dm_addr_i = 32'h10;
    repeat (3) begin
      @(posedge clock_i);
      #1;
    end
    check_eq("xfer_mem_req_held", 32'(mem_req_o), 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("xfer_rst_mem_req", 32'(mem_req_o), 32'd0);
    check_eq("xfer_rst_err",     32'(err_o),     32'd0);
    dm_req_i  = 1'b0;
    dm_addr_i = '0;
    @(negedge clock_i);
    reset_n_i = 1'b1;
    repeat (4) begin
      @(posedge clock_i);
      #1;
      check_eq("xfer_rst_no_ack", 32'(dm_ack_o),  32'd0);
      check_eq("xfer_rst_idle",   32'(mem_req_o), 32'd0);
    end

    cyc = 0; free_cyc = 0; busy = 0; streak = 0; xk = 0; dm_run = 0;
    exp_err = 0; exp_if_rdata = '0; exp_dm_rdata = '0;
    t_dm = 0; t_we = 0; t_to = 0; t_addr = '0; t_wdata = '0; t_dec = 0; t_waits = 0;

    repeat (800) step(30, 30, 3, 1'b0);
    dm_run = 0;
    repeat (400) step(100, 100, 0, 1'b1);
    repeat (600) step(50, 50, 20, 1'b0);
    repeat (60)  step(0, 0, 0, 1'b0);

    for (int i = 0; i < 16; i++) check_eq("mem_contents", slave_mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage (read-only) and the data-memory stage (read/write) of the five-stage MIPS pipeline.
- Sequences each memory transaction through a req/ready handshake and returns data with a one-cycle ack pulse.
- Drives per-stage stall lines so the pipeline freezes while its access is pending.
- Enforces data-stage priority with bounded fetch starvation, plus a ready-timeout guard.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- MAX_DM_BURST, 2, consecutive data-stage grants allowed while a fetch waits; the next grant then goes to the fetch
- TIMEOUT, 15, XFER cycles without mem_ready before the transaction is aborted

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetch data, valid with if_ack
- if_ack  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, level, held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  read data, valid with dm_ack
- dm_ack  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request, held until mem_ready or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- stall_if  out  1  combinational: if_req & ~if_ack
- stall_dm  out  1  combinational: dm_req & ~dm_ack
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, starvation counter=0, timeout counter=0.
  - mem_req, mem_we, if_ack, dm_ack and err are 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
  - A reset during XFER abandons the transaction; no ack is issued.
- All outputs except stall_if and stall_dm are registered.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - Samples if_req and dm_req, then chooses a winner:
    - dm_req only -> DM.
    - if_req only -> IF.
    - Both, and starve_cnt < MAX_DM_BURST -> DM, and starve_cnt increments.
    - Both, and starve_cnt == MAX_DM_BURST -> IF.
  - starve_cnt clears on every IF grant.
  - On a grant, registers mem_addr, mem_we and mem_wdata from the winner. mem_we=0 for IF.
  - Sets mem_req=1, loads tcnt=0 and goes to XFER.
- XFER:
  - If mem_ready=1: drop mem_req and mem_we. For a read, capture mem_rdata into the winner's rdata register. Go to RESP.
  - Else if tcnt==TIMEOUT-1: drop mem_req and mem_we, load rdata=32'hDEADBEEF for reads, set err=1, go to RESP.
  - Else tcnt increments.
  - Request inputs are ignored in XFER. Address and data are latched at grant, so requester changes have no effect.
- RESP:
  - Winner's ack=1 for exactly this cycle; go to IDLE.
  - Requesters sample ack at the closing edge and drop or replace req. Any req seen in IDLE is therefore a new request.
- Latency with zero-wait memory (mem_ready already high when mem_req rises):
  - req seen in IDLE at cycle N, mem_req high in N+1, ack in N+2.
  - Every additional wait cycle adds 1.
- Throughput: one transaction per 3 cycles minimum, regardless of requester.
- Non-winning rdata is unchanged and ack stays 0. if_ack and dm_ack are never high in the same cycle.
- Write transactions leave dm_rdata unchanged.
- Dropping req before ack is a protocol violation. The granted transaction completes and acks anyway.
- err holds until reset. Operation continues normally after a timeout.

Test Plan:
1. Reset mid-XFER, with dm_req=1 and mem_ready held 0 -> assert reset_n=0 -> mem_req=0 and err=0 immediately. No dm_ack follows. After reset, IDLE accepts if_req normally.
2. Isolated fetch, if_addr=0x00000004, mem_ready tied 1 and mem_rdata=0x8C220000 -> if_ack exactly 2 cycles after if_req, if_rdata=0x8C220000. stall_if is high for those 2 cycles.
3. Data write, dm_we=1, dm_addr=0x100, dm_wdata=0xCAFEF00D, mem_ready delayed 3 cycles -> mem_we=1 and mem_addr=0x100 held 4 cycles. dm_ack at cycle N+5. dm_rdata unchanged.
4. if_req and dm_req both held continuously, with re-request after every ack -> grant order DM, DM, IF, DM, DM, IF. Never more than 2 consecutive DM acks.
5. mem_ready never asserted on a read -> mem_req drops after 15 XFER cycles. dm_ack pulses with dm_rdata=0xDEADBEEF. err=1 and stays 1 through a following successful fetch.
6. Zero-wait back-to-back fetches at addresses 0x0, 0x4, 0x8 -> acks spaced exactly 3 cycles apart, each if_rdata matching its own address's memory word.
